pipelined_subtractor: RTL and testbench

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

---
 rtl/pipelined_subtractor_pkg.sv | 21 ++
 rtl/sub_slice.sv | 22 ++
 rtl/pipelined_subtractor.sv | 129 ++++++++++++
 tb/tb_pipelined_subtractor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_subtractor_pkg.sv
// Shared arithmetic definitions for the pipelined subtractor.
// Holds the default operand width and slice width, the derived stage count,
// and the payload carried by every pipeline slot.
package pipelined_subtractor_pkg;

  localparam int unsigned Width  = 32;
  localparam int unsigned Slice  = 8;
  localparam int unsigned Stages = Width / Slice;

  // One pipeline slot. a/b hold the operand slices not yet consumed, shifted so
  // the next slice to resolve always sits in the low bits. d accumulates the
  // completed low slices of the difference; carry feeds the next slice.
  typedef struct packed {
    logic             valid;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic [Width-1:0] d;
    logic             carry;
  } stage_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational slice of the subtractor: {cout, sum} = a + ~b + cin.
// Ports:
//   a_i    - minuend slice
//   b_i    - subtrahend slice (inverted internally)
//   cin_i  - carry in (1 for the lowest slice)
//   sum_o  - difference slice
//   cout_o - carry out (inverse of the borrow)
module sub_slice #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, ~b_i} + (Width + 1)'(cin_i);
  end

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined unsigned subtractor, D = {0,A} - {0,B} mod 2^(WIDTH+1).
// Slot 0 registers the accepted operands; compute stage k resolves bits
// [k*SLICE +: SLICE] out of slot k into slot k+1 (the last one into the output
// register), giving a latency of WIDTH/SLICE cycles. Valid/ready handshake on
// both sides with bubble-collapsing flow control.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid, in_ready   - input handshake for A/B
//   A, B                 - unsigned operands
//   out_valid, out_ready - output handshake for D
//   D                    - difference; D[WIDTH] is the borrow (A < B)
// WIDTH must be a multiple of SLICE, no larger than the package Width, and
// span at least two slices.
module pipelined_subtractor
  import pipelined_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = Width,
  parameter int unsigned SLICE = Slice
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   D
);

  localparam int unsigned N = WIDTH / SLICE;

  stage_t           slot_q [N];
  stage_t           nxt [N-1];
  stage_t           in_stage;
  logic [SLICE-1:0] slice_sum [N];
  logic [N-1:0]     slice_cout;
  logic [N-1:0]     adv;
  logic             out_adv;
  logic             in_fire;
  logic             out_valid_q;
  logic             out_borrow_q;
  logic [WIDTH-1:0] out_d_q;
  logic [WIDTH-1:0] out_d_next;

  for (genvar k = 0; k < N; k++) begin : g_slice
    sub_slice #(
      .Width(SLICE)
    ) u_sub_slice (
      .a_i   (slot_q[k].a[SLICE-1:0]),
      .b_i   (slot_q[k].b[SLICE-1:0]),
      .cin_i (slot_q[k].carry),
      .sum_o (slice_sum[k]),
      .cout_o(slice_cout[k])
    );
  end

  // Flow control, walked from the output back to the input so a stalled slot
  // only blocks the slots directly behind it.
  always_comb begin
    logic open;
    logic go;
    out_adv = out_valid_q && out_ready;
    open    = !out_valid_q || out_adv;
    adv     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      go     = slot_q[k].valid && open;
      adv[k] = go;
      open   = !slot_q[k].valid || go;
    end
    in_ready = !rst && open;
    in_fire  = in_valid && in_ready;
  end

  always_comb begin
    in_stage                = '0;
    in_stage.valid          = 1'b1;
    in_stage.a[WIDTH-1:0]   = A;
    in_stage.b[WIDTH-1:0]   = B;
    in_stage.carry          = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < N - 1; k++) begin
      nxt[k]                      = slot_q[k];
      nxt[k].a                    = slot_q[k].a >> SLICE;
      nxt[k].b                    = slot_q[k].b >> SLICE;
      nxt[k].d[k*SLICE +: SLICE]  = slice_sum[k];
      nxt[k].carry                = slice_cout[k];
    end
    out_d_next                          = slot_q[N-1].d[WIDTH-1:0];
    out_d_next[(N-1)*SLICE +: SLICE]    = slice_sum[N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_borrow_q <= 1'b0;
      out_d_q      <= '0;
    end else begin
      if (in_fire) begin
        slot_q[0] <= in_stage;
      end else if (adv[0]) begin
        slot_q[0].valid <= 1'b0;
      end
      for (int k = 1; k < N; k++) begin
        if (adv[k-1]) begin
          slot_q[k] <= nxt[k-1];
        end else if (adv[k]) begin
          slot_q[k].valid <= 1'b0;
        end
      end
      if (adv[N-1]) begin
        out_valid_q  <= 1'b1;
        out_d_q      <= out_d_next;
        out_borrow_q <= ~slice_cout[N-1];
      end else if (out_adv) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign D         = {out_borrow_q, out_d_q};

endmodule

// File: tb/tb_pipelined_subtractor.sv
module tb_pipelined_subtractor;

  localparam int unsigned W = 32;
  localparam int unsigned S = 8;
  localparam int unsigned N = W / S;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W:0]   D;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         ready_mode = 0;  // 0: high, 1: low, 2: random
  int         last_acc = 0;
  int         pops = 0;
  int         last_pop_cyc = 0;
  logic       prev_stall = 1'b0;
  logic [W:0] prev_d = '0;
  logic [W:0] exp_q [$];

  logic [W-1:0] va [8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0100,
                           32'h1234_5678, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
  logic [W-1:0] vb [8] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFF6,
                           32'h0123_4567, 32'h8000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
  logic [W:0]   vd [8] = '{33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_0000_0000, 33'h1_0000_010A,
                           33'h0_1111_1111, 33'h1_FFFF_FFFF, 33'h0_0000_FFFF, 33'h0_0000_0000};

  pipelined_subtractor #(
    .WIDTH(W),
    .SLICE(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled result holds steady.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", (W + 1)'(out_valid), (W + 1)'(1));
        check("stall_hold", D, prev_d);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h, expected no output (cycle %0d)", D, cyc);
        end else begin
          check("result", D, exp_q.pop_front());
          pops++;
          last_pop_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = D;
    end
  end

  // Presents one pair and holds it until accepted; returns #1 after the
  // accepting edge with in_valid still high so pairs can run back to back.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] expd);
    int w = 0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expd);
        last_acc = cyc + 1;
        break;
      end
      w++;
      if (w > 500) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", w);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    check("drained", (W + 1)'(exp_q.size()), '0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int first_acc;
    int pops0;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", (W + 1)'(in_ready), '0);
    check("reset_out_valid", (W + 1)'(out_valid), '0);
    check("reset_d", D, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", (W + 1)'(in_ready), (W + 1)'(1));
    @(posedge clk);
    #1;

    // Basic result and latency
    send(32'd5, 32'd3, 33'h0_0000_0002);
    in_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 50);
    check("latency", (W + 1)'(cyc - last_acc), (W + 1)'(N));
    @(posedge clk);
    #1;
    drain();

    // Directed vectors, back to back
    for (int i = 0; i < 8; i++) send(va[i], vb[i], vd[i]);
    drain();

    // Streaming: 300 pairs, values in -10..255 wrapped to 32 bits
    pops0 = pops;
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom_range(0, 265) - 10);
      b = W'($urandom_range(0, 265) - 10);
      send(a, b, ref_sub(a, b));
      if (i == 0) first_acc = last_acc;
    end
    drain();
    check("stream_accept_rate", (W + 1)'(last_acc - first_acc), (W + 1)'(299));
    check("stream_output_rate", (W + 1)'(last_pop_cyc - first_acc), (W + 1)'(299 + N));
    check("stream_count", (W + 1)'(pops - pops0), (W + 1)'(300));

    // Backpressure: fill every slot, then hold the consumer off for 10 cycles
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i <= N; i++) begin
      a = W'(i * 32'h0101_0101);
      b = W'(i * 3 + 1);
      send(a, b, ref_sub(a, b));
    end
    in_valid = 1'b1;
    A        = 32'h0000_1000;
    B        = 32'h0000_2000;
    repeat (10) begin
      @(negedge clk);
      check("full_in_ready", (W + 1)'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    send(32'h0000_1000, 32'h0000_2000, 33'h1_FFFF_F000);
    drain();

    // Random handshakes on both sides
    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      while ($urandom_range(0, 1) == 0) idle(1);
      a = $urandom;
      b = $urandom;
      send(a, b, ref_sub(a, b));
    end
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three results in flight
    send(32'd100, 32'd1, 33'h0_0000_0063);
    send(32'd1, 32'd100, 33'h1_FFFF_FF9D);
    send(32'd7, 32'd7, 33'h0_0000_0000);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("rst_in_ready", (W + 1)'(in_ready), '0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", (W + 1)'(out_valid), '0);
    check("rst_d", D, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", (W + 1)'(in_ready), (W + 1)'(1));
    @(posedge clk);
    #1;
    idle(10);
    check("no_stale_out", (W + 1)'(out_valid), '0);
    send(32'd9, 32'd4, 33'h0_0000_0005);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
